// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/wb sequencing with bus timeout and trap handling.
// Optional performance counters (cycle_cnt, instr_cnt) are built only when PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [6:0]       opcode,
  input  logic             zero_flag,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             rf_write,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             mem_2_reg,
  output logic             busy,
  output logic             retired,
  output logic             illegal_op,
  output logic             bus_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_BR, C_JAL
  } cls_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, next_state;
  cls_t       cls, dec_cls;
  logic       dec_legal;
  logic [7:0] wait_cnt, wait_next;
  logic       illegal_q, bus_err_q;
  logic       set_illegal, set_bus_err, clr_flags;
  logic       retire;

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = C_R;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LD;
      7'b0100011: dec_cls = C_ST;
      7'b1100011: dec_cls = C_BR;
      7'b1101111: dec_cls = C_JAL;
      default:    dec_legal = 1'b0;
    endcase
  end

  // State register and trap flags; wait counter restarts on every new request
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
      if (clr_flags) begin
        illegal_q <= 1'b0;
        bus_err_q <= 1'b0;
      end else begin
        if (set_illegal) illegal_q <= 1'b1;
        if (set_bus_err) bus_err_q <= 1'b1;
      end
    end
  end

  // Instruction class is captured once in DECODE so later states ignore IR changes
  always_ff @(posedge clk) begin
    if (state == S_DECODE) cls <= dec_cls;
  end

  always_comb begin
    next_state  = state;
    wait_next   = '0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    clr_flags   = 1'b0;
    retire      = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    rf_write    = 1'b0;
    pc_sel      = 2'b00;
    alu_op      = 2'b00;
    alu_src     = 1'b0;
    mem_2_reg   = 1'b0;
    busy        = (state != S_IDLE);
    illegal_op  = illegal_q;
    bus_err     = bus_err_q;
    case (state)
      S_IDLE: begin
        if (enable) next_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_bus_err = 1'b1;
          next_state  = S_TRAP;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          next_state = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          next_state  = S_TRAP;
        end
      end
      S_EXEC: begin
        case (cls)
          C_R: begin
            alu_op     = 2'b10;
            next_state = S_WB;
          end
          C_I: begin
            alu_op     = 2'b10;
            alu_src    = 1'b1;
            next_state = S_WB;
          end
          C_LD, C_ST: begin
            alu_src    = 1'b1;
            next_state = S_MEM;
          end
          C_BR: begin
            alu_op   = 2'b01;
            pc_write = zero_flag;
            pc_sel   = 2'b01;
            retire   = 1'b1;
          end
          default: begin
            rf_write = 1'b1;
            pc_write = 1'b1;
            pc_sel   = 2'b10;
            retire   = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_ST);
        if (dmem_ack) begin
          if (cls == C_ST) retire = 1'b1;
          else             next_state = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          set_bus_err = 1'b1;
          next_state  = S_TRAP;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        rf_write  = 1'b1;
        mem_2_reg = (cls == C_LD);
        retire    = 1'b1;
      end
      S_TRAP: begin
        if (!enable) begin
          clr_flags  = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
    retired = retire;
    if (retire) next_state = enable ? S_FETCH : S_IDLE;
  end

`ifdef PERF_CNT_EN
  // Free-running wrap-around counters
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy)    cycle_cnt <= cycle_cnt + 1'b1;
      if (retired) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds expected per-cycle traces from instruction-level rules
// (class, ack delays, enable), replays them with random noise on don't-care inputs.
module tb_multicycle_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n, enable, zero_flag, imem_ack, dmem_ack;
  logic [6:0] opcode;
  logic imem_req, dmem_req, dmem_we, ir_write, pc_write, rf_write;
  logic [1:0] pc_sel, alu_op;
  logic alu_src, mem_2_reg, busy, retired, illegal_op, bus_err;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode), .zero_flag(zero_flag),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write), .rf_write(rf_write),
    .pc_sel(pc_sel), .alu_op(alu_op), .alu_src(alu_src), .mem_2_reg(mem_2_reg),
    .busy(busy), .retired(retired), .illegal_op(illegal_op), .bus_err(bus_err)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  wire [15:0] obs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, rf_write, pc_sel, alu_op,
                     alu_src, mem_2_reg, busy, retired, illegal_op, bus_err};

  typedef struct {
    logic       rst_n, en, ia, da, zf;
    logic [6:0] op;
    logic [15:0] exp;
  } cyc_t;

  cyc_t        tr[$];
  logic [15:0] got[$];
  int checks = 0;
  int errors = 0;

  // Instruction kinds: 0 R, 1 I-arith, 2 load, 3 store, 4 branch, 5 jal, 6 illegal
  logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic [15:0] mk(input logic ireq, dreq, we, irw, pcw, rfw,
                                     input logic [1:0] psel, aop,
                                     input logic asrc, m2r, bsy, ret, ill, berr);
    return {ireq, dreq, we, irw, pcw, rfw, psel, aop, asrc, m2r, bsy, ret, ill, berr};
  endfunction

  function automatic logic [6:0] illegal_opcode();
    logic [6:0] o;
    logic ok;
    do begin
      o  = rop();
      ok = 1'b1;
      for (int i = 0; i < 6; i++) if (o == ops[i]) ok = 1'b0;
    end while (!ok);
    return o;
  endfunction

  task automatic push(input logic rst_n, en, ia, da, zf, input logic [6:0] op, input logic [15:0] exp);
    cyc_t c;
    c.rst_n = rst_n; c.en = en; c.ia = ia; c.da = da; c.zf = zf; c.op = op; c.exp = exp;
    tr.push_back(c);
  endtask

  task automatic add_idle(input logic en);
    push(1'b1, en, rb(), rb(), rb(), rop(), 16'h0);
  endtask

  // Expected cycles of one instruction, starting in FETCH. Memory delays must stay below TIMEOUT.
  task automatic add_instr(input int kind, input logic [6:0] op, input int idly, input int ddly,
                           input logic zf, input logic en_after);
    logic st;
    st = (kind == 3);
    for (int i = 0; i < idly; i++)
      push(1'b1, rb(), 1'b0, rb(), rb(), rop(), mk(1,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0,0));
    push(1'b1, rb(), 1'b1, rb(), rb(), rop(), mk(1,0,0,1,1,0,2'b00,2'b00,0,0,1,0,0,0));
    push(1'b1, rb(), rb(), rb(), rb(), op, mk(0,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0,0));
    case (kind)
      0, 1: begin
        push(1'b1, rb(), rb(), rb(), rb(), op, mk(0,0,0,0,0,0,2'b00,2'b10,kind == 1,0,1,0,0,0));
        push(1'b1, en_after, rb(), rb(), rb(), op, mk(0,0,0,0,0,1,2'b00,2'b00,0,0,1,1,0,0));
      end
      2, 3: begin
        push(1'b1, rb(), rb(), rb(), rb(), op, mk(0,0,0,0,0,0,2'b00,2'b00,1,0,1,0,0,0));
        for (int i = 0; i < ddly; i++)
          push(1'b1, rb(), rb(), 1'b0, rb(), op, mk(0,1,st,0,0,0,2'b00,2'b00,0,0,1,0,0,0));
        push(1'b1, st ? en_after : rb(), rb(), 1'b1, rb(), op,
             mk(0,1,st,0,0,0,2'b00,2'b00,0,0,1,st,0,0));
        if (!st)
          push(1'b1, en_after, rb(), rb(), rb(), op, mk(0,0,0,0,0,1,2'b00,2'b00,0,1,1,1,0,0));
      end
      4: push(1'b1, en_after, rb(), rb(), zf, op, mk(0,0,0,0,zf,0,2'b01,2'b01,0,0,1,1,0,0));
      5: push(1'b1, en_after, rb(), rb(), rb(), op, mk(0,0,0,0,1,1,2'b10,2'b00,0,0,1,1,0,0));
      default: begin
        for (int i = 0; i < 1 + $urandom_range(0, 3); i++)
          push(1'b1, 1'b1, rb(), rb(), rb(), rop(), mk(0,0,0,0,0,0,2'b00,2'b00,0,0,1,0,1,0));
        push(1'b1, 1'b0, rb(), rb(), rb(), rop(), mk(0,0,0,0,0,0,2'b00,2'b00,0,0,1,0,1,0));
      end
    endcase
  endtask

  task automatic play();
    got.delete();
    foreach (tr[i]) begin
      @(negedge clk);
      arst_n = tr[i].rst_n; enable = tr[i].en; imem_ack = tr[i].ia;
      dmem_ack = tr[i].da; zero_flag = tr[i].zf; opcode = tr[i].op;
      #1;
      got.push_back(obs);
    end
  endtask

  task automatic test_reset();
    tr.delete();
    arst_n = 1'b0; enable = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; zero_flag = 1'b0; opcode = 7'h33;
    @(posedge clk);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, rb(), rb(), rb(), rop(), 16'h0);
    for (int i = 0; i < 2; i++) push(1'b1, 1'b0, rb(), rb(), rb(), rop(), 16'h0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (got[i] !== tr[i].exp) begin
        errors++;
        $display("FAIL reset cyc %0d got %h expected %h", i, got[i], tr[i].exp);
      end
    end
`ifdef PERF_CNT_EN
    checks++;
    if (cycle_cnt !== '0 || instr_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d expected 0/0", cycle_cnt, instr_cnt);
    end
`endif
  endtask

  task automatic test_rtype();
    tr.delete();
    add_idle(1'b1);
    add_instr(0, ops[0], 0, 0, 1'b0, 1'b0);
    add_idle(1'b0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (got[i] !== tr[i].exp) begin
        errors++;
        $display("FAIL rtype cyc %0d got %h expected %h", i, got[i], tr[i].exp);
      end
    end
  endtask

  task automatic test_load_delay();
    tr.delete();
    add_idle(1'b1);
    add_instr(2, ops[2], 0, 3, 1'b0, 1'b1);
    add_instr(3, ops[3], 2, 1, 1'b0, 1'b0);
    add_idle(1'b0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (got[i] !== tr[i].exp) begin
        errors++;
        $display("FAIL load_delay cyc %0d got %h expected %h", i, got[i], tr[i].exp);
      end
    end
  endtask

  task automatic test_branch();
    tr.delete();
    add_idle(1'b1);
    add_instr(4, ops[4], 0, 0, 1'b1, 1'b1);
    add_instr(4, ops[4], 0, 0, 1'b0, 1'b1);
    add_instr(5, ops[5], 1, 0, 1'b0, 1'b0);
    add_idle(1'b0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (got[i] !== tr[i].exp) begin
        errors++;
        $display("FAIL branch cyc %0d got %h expected %h", i, got[i], tr[i].exp);
      end
    end
  endtask

  task automatic test_illegal();
    tr.delete();
    add_idle(1'b1);
    add_instr(6, 7'b1111111, 0, 0, 1'b0, 1'b0);
    add_idle(1'b0);
    add_idle(1'b1);
    add_instr(1, ops[1], 0, 0, 1'b0, 1'b0);
    add_idle(1'b0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (got[i] !== tr[i].exp) begin
        errors++;
        $display("FAIL illegal cyc %0d got %h expected %h", i, got[i], tr[i].exp);
      end
    end
  endtask

  task automatic test_timeout();
    tr.delete();
    add_idle(1'b1);
    for (int i = 0; i < TIMEOUT; i++)
      push(1'b1, rb(), 1'b0, rb(), rb(), rop(), mk(1,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0,0));
    for (int i = 0; i < 3; i++)
      push(1'b1, 1'b1, rb(), rb(), rb(), rop(), mk(0,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0,1));
    push(1'b1, 1'b0, rb(), rb(), rb(), rop(), mk(0,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0,1));
    add_idle(1'b0);
    // reset in the middle of a pending fetch
    add_idle(1'b1);
    for (int i = 0; i < 2; i++)
      push(1'b1, 1'b1, 1'b0, rb(), rb(), rop(), mk(1,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0,0));
    push(1'b0, 1'b1, 1'b0, rb(), rb(), rop(), mk(1,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0,0));
    push(1'b0, 1'b1, rb(), rb(), rb(), rop(), 16'h0);
    push(1'b1, 1'b0, rb(), rb(), rb(), rop(), 16'h0);
    add_idle(1'b1);
    add_instr(0, ops[0], TIMEOUT - 1, 0, 1'b0, 1'b0);
    add_idle(1'b0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (got[i] !== tr[i].exp) begin
        errors++;
        $display("FAIL timeout cyc %0d got %h expected %h", i, got[i], tr[i].exp);
      end
    end
  endtask

  task automatic test_random();
    int kind;
    logic en_after;
    tr.delete();
    add_idle(1'b1);
    for (int n = 0; n < 40; n++) begin
      kind     = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 5));
      en_after = (n == 39) ? 1'b0 : ($urandom_range(0, 3) != 0);
      add_instr(kind, (kind == 6) ? illegal_opcode() : ops[kind], $urandom_range(0, TIMEOUT - 1),
                $urandom_range(0, TIMEOUT - 1), rb(), en_after);
      if ((kind == 6 || !en_after) && n != 39) begin
        for (int k = 0; k < $urandom_range(0, 2); k++) add_idle(1'b0);
        add_idle(1'b1);
      end
    end
    add_idle(1'b0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (got[i] !== tr[i].exp) begin
        errors++;
        $display("FAIL random cyc %0d got %h expected %h", i, got[i], tr[i].exp);
      end
    end
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    int nbusy, nret;
    tr.delete();
    push(1'b0, 1'b0, rb(), rb(), rb(), rop(), 16'h0);
    add_idle(1'b1);
    for (int n = 0; n < 10; n++) add_instr(0, ops[0], 0, 0, 1'b0, n != 9);
    add_idle(1'b0);
    nbusy = 0;
    nret  = 0;
    foreach (tr[i]) begin
      if (tr[i].exp[3]) nbusy++;
      if (tr[i].exp[2]) nret++;
    end
    play();
    foreach (tr[i]) begin
      checks++;
      if (got[i] !== tr[i].exp) begin
        errors++;
        $display("FAIL perf cyc %0d got %h expected %h", i, got[i], tr[i].exp);
      end
    end
    checks++;
    if (cycle_cnt !== CNT_W'(nbusy)) begin
      errors++;
      $display("FAIL cycle_cnt got %0d expected %0d", cycle_cnt, nbusy % (1 << CNT_W));
    end
    checks++;
    if (instr_cnt !== CNT_W'(nret)) begin
      errors++;
      $display("FAIL instr_cnt got %0d expected %0d", instr_cnt, nret % (1 << CNT_W));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_delay();
    test_branch();
    test_illegal();
    test_timeout();
    test_random();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles a memory request may wait for acknowledge; legal range 1..255.
REQ-002 Parameter CNT_W, default 32: width of performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 arst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  run request; sampled at instruction boundaries only.
REQ-006 opcode  input  7  instruction[6:0] from instruction register.
REQ-007 zero_flag  input  1  ALU zero result, valid in EXEC.
REQ-008 imem_ack / dmem_ack  input  1 each  memory acknowledge, completes the request in the same cycle.
REQ-009 imem_req, dmem_req, dmem_we  output  1 each  memory request strobes.
REQ-010 ir_write, pc_write, rf_write  output  1 each  register load enables.
REQ-011 pc_sel  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-012 alu_op  output  2  00 add, 01 compare, 10 funct-decoded; alu_src, mem_2_reg  output  1 each.
REQ-013 busy, retired, illegal_op, bus_err  output  1 each  status; retired is a one-cycle pulse.
REQ-014 cycle_cnt, instr_cnt  output  CNT_W each  present only under PERF_CNT_EN.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; encoding free, single state register.
REQ-016 IDLE: all strobes 0, busy 0; enable=1 -> FETCH next cycle.
REQ-017 FETCH: imem_req=1 held until imem_ack; on ack assert ir_write=1, pc_write=1, pc_sel=00, go DECODE.
REQ-018 DECODE: no strobes; opcode 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 -> EXEC; any other -> TRAP with illegal_op=1.
REQ-019 EXEC R-type (0110011): alu_op=10, alu_src=0 -> WB; I-arith (0010011): alu_op=10, alu_src=1 -> WB.
REQ-020 EXEC load/store: alu_op=00, alu_src=1 -> MEM.
REQ-021 EXEC branch: alu_op=01, alu_src=0; pc_write=zero_flag, pc_sel=01; instruction retires.
REQ-022 EXEC jal: rf_write=1, pc_write=1, pc_sel=10; instruction retires.
REQ-023 MEM: dmem_req=1, dmem_we=1 for store; held until dmem_ack; store retires on ack, load -> WB on ack.
REQ-024 WB: rf_write=1, mem_2_reg=1 for load else 0; instruction retires.
REQ-025 Retire cycle: retired=1; next state FETCH if enable=1, else IDLE.
REQ-026 Latency with ack in first request cycle: branch/jal 3 cycles, R/I/store 4, load 5; each non-acked request cycle adds exactly 1.
REQ-027 Wait counter counts non-acked cycles of the current request; reaching TIMEOUT without ack -> TRAP with bus_err=1, request deasserted next cycle.
REQ-028 Ack outside FETCH/MEM, or ack for the non-requested memory, SHALL be ignored.
REQ-029 TRAP: all strobes 0, busy 1, flag held; exits to IDLE only when enable=0, clearing illegal_op and bus_err.
REQ-030 busy=1 in every state except IDLE.
REQ-031 All outputs are registered-state decodes; no combinational path from enable to any strobe.

Reset
REQ-032 arst_n=0 at a rising edge forces IDLE, clears wait counter, flags and counters, regardless of state or pending request.
REQ-033 During and after reset all outputs are 0 until the first post-reset transition.
REQ-034 Pending memory requests are abandoned on reset; no acknowledge is required.

Configuration
REQ-035 Macro PERF_CNT_EN: when defined, cycle_cnt increments every cycle busy=1 and instr_cnt on every retired pulse, both wrapping at 2^CNT_W; when undefined, ports and counters are absent and all other behaviour is identical.

Verification
REQ-036 Reset, enable=1, opcode 0110011, acks immediate -> states FETCH,DECODE,EXEC,WB; retired at cycle 4; rf_write once, mem_2_reg=0.
REQ-037 Load 0000011, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, total 8 cycles, WB with mem_2_reg=1.
REQ-038 Branch 1100011 with zero_flag=1 then 0 -> pc_write with pc_sel=01 in first, no pc_write in EXEC in second; 3 cycles each.
REQ-039 Opcode 1111111 -> illegal_op=1 from cycle 3, held in TRAP while enable=1; enable=0 -> IDLE, flag cleared.
REQ-040 TIMEOUT=4, imem_ack never -> imem_req high 4 cycles, then bus_err=1; arst_n=0 mid-wait -> IDLE, all outputs 0.
REQ-041 PERF_CNT_EN defined, 10 back-to-back R-types -> instr_cnt=10, cycle_cnt=40; CNT_W=4 wrap checked.
